// File: rtl/kamacore_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// kamacore_pkg : shared widths, memory FSM states and byte-merge helper. Rev 1.0
// -----------------------------------------------------------------------------
package kamacore_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int ADDR_WIDTH = 10;
  // Widest word strb_merge can handle; callers zero-extend and truncate.
  localparam int MERGE_W    = 256;

  typedef enum logic [0:0] {
    MEM_CLEAR = 1'b0,
    MEM_RUN   = 1'b1
  } mem_state_t;

  function automatic logic [MERGE_W-1:0] strb_merge(
    input logic [MERGE_W-1:0]   old_w,
    input logic [MERGE_W-1:0]   new_w,
    input logic [MERGE_W/8-1:0] strb
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_W/8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kamacore_mem_rd_pipe.sv
`default_nettype none
// -----------------------------------------------------------------------------
// kamacore_mem_rd_pipe : per-port valid/data delay line of RD_LATENCY stages. Rev 1.0
// -----------------------------------------------------------------------------
module kamacore_mem_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  if (RD_LATENCY == 0) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign vld_o  = vld_i;
    assign data_o = data_i;
  end else begin : g_reg
    logic [RD_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

    // Data stages load only behind a valid so the output holds between responses.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int s = 0; s < RD_LATENCY; s++) data_q[s] <= '0;
      end else begin
        vld_q[0] <= vld_i;
        if (vld_i) data_q[0] <= data_i;
        for (int s = 1; s < RD_LATENCY; s++) begin
          vld_q[s] <= vld_q[s-1];
          if (vld_q[s-1]) data_q[s] <= data_q[s-1];
        end
      end
    end

    assign vld_o  = vld_q[RD_LATENCY-1];
    assign data_o = data_q[RD_LATENCY-1];
  end

endmodule
`default_nettype wire

// File: rtl/kamacore_memory_mp.sv
`default_nettype none
// -----------------------------------------------------------------------------
// kamacore_memory_mp : 1W/NR RAM with hardware clear and range trapping. Rev 1.0
// Option macro KAMACORE_MEM_FWD_EN: same-cycle write-to-read forwarding.
// -----------------------------------------------------------------------------
module kamacore_memory_mp
  import kamacore_pkg::*;
#(
  parameter int DATA_WIDTH     = CPU_WIDTH,
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int RAM_SIZE       = 1024,
  parameter int NUM_RD_PORTS   = 2,
  parameter int RD_LATENCY     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic                                 init_done,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [DATA_WIDTH/8-1:0]              wr_strb,
  input  logic [NUM_RD_PORTS-1:0]              rd_en,
  input  logic [NUM_RD_PORTS*MEM_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]              rd_vld,
  output logic                                 oob_err
);

  localparam int IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [MEM_ADDR_WIDTH:0] C_RAM_SIZE = (MEM_ADDR_WIDTH+1)'(RAM_SIZE);
  localparam logic [IDX_W-1:0]        C_LAST     = IDX_W'(RAM_SIZE - 1);

  mem_state_t                state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic                      oob_q, oob_d;
  logic [DATA_WIDTH-1:0]     mem_q [RAM_SIZE];

  logic                      run;
  logic                      wr_acc;
  logic                      wr_inr;
  logic [IDX_W-1:0]          wr_idx;
  logic [DATA_WIDTH-1:0]     wr_word;
  logic [NUM_RD_PORTS-1:0]   rd_oob;

  assign run     = (state_q == MEM_RUN);
  assign wr_acc  = wr_valid && run;
  // Range check at full address width, so RAM_SIZE never aliases onto word 0.
  assign wr_inr  = ({1'b0, wr_addr} < C_RAM_SIZE);
  assign wr_idx  = wr_addr[IDX_W-1:0];
  assign wr_word = DATA_WIDTH'(strb_merge(MERGE_W'(mem_q[wr_idx]), MERGE_W'(wr_data),
                                          (MERGE_W/8)'(wr_strb)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MEM_CLEAR;
      cnt_q   <= '0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oob_q   <= oob_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    oob_d     = oob_q;
    init_done = 1'b0;
    wr_ready  = 1'b0;
    case (state_q)
      MEM_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          state_d = MEM_RUN;
          cnt_d   = '0;
        end
      end
      MEM_RUN: begin
        init_done = 1'b1;
        wr_ready  = 1'b1;
        if ((wr_acc && !wr_inr) || (|rd_oob)) oob_d = 1'b1;
      end
      default: state_d = MEM_CLEAR;
    endcase
  end

  assign oob_err = oob_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == MEM_CLEAR)   mem_q[cnt_q]  <= '0;
      else if (wr_acc && wr_inr)  mem_q[wr_idx] <= wr_word;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic                      inr;
    logic [DATA_WIDTH-1:0]     word;

    assign addr      = rd_addr[p*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
    assign inr       = ({1'b0, addr} < C_RAM_SIZE);
    assign rd_oob[p] = rd_en[p] && !inr;

`ifdef KAMACORE_MEM_FWD_EN
    assign word = !(run && inr) ? '0 :
                  (wr_acc && wr_inr && (wr_addr == addr)) ? wr_word :
                  mem_q[addr[IDX_W-1:0]];
`else
    assign word = (run && inr) ? mem_q[addr[IDX_W-1:0]] : '0;
`endif

    kamacore_mem_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (rd_en[p] && run),
      .data_i (word),
      .vld_o  (rd_vld[p]),
      .data_o (rd_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_kamacore_memory_mp.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_kamacore_memory_mp : directed vector bench for kamacore_memory_mp. Rev 1.0
// -----------------------------------------------------------------------------
module tb_kamacore_memory_mp;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int RS  = 64;
  localparam int NP  = 2;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              init_done;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [DW/8-1:0]   wr_strb = '0;
  logic [NP-1:0]     rd_en = '0;
  logic [NP*AW-1:0]  rd_addr = '0;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_vld;
  logic              oob_err;

  kamacore_memory_mp #(
    .DATA_WIDTH     (DW),
    .MEM_ADDR_WIDTH (AW),
    .RAM_SIZE       (RS),
    .NUM_RD_PORTS   (NP),
    .RD_LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld),
    .oob_err   (oob_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [3:0]    ws;
    logic [NP-1:0] re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic          eoob;
  } vec_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] last_d [NP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic reset_clear(input string tag);
    int   n;
    logic bad;
    rst_n = 1'b0; wr_valid = 1'b0; rd_en = '0;
    tick; tick;
    check({tag, "_rst_init_done"}, init_done, 0);
    check({tag, "_rst_wr_ready"}, wr_ready, 0);
    check({tag, "_rst_rd_vld"}, rd_vld, 0);
    check({tag, "_rst_rd_data"}, rd_data, 0);
    check({tag, "_rst_oob"}, oob_err, 0);
    // Held write and out-of-range reads during clear must be ignored.
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_addr = 8'd3; wr_data = '1; wr_strb = '1;
    rd_en = 2'b11; rd_addr = {8'd200, 8'd3};
    n = 0; bad = 1'b0;
    while (!init_done && n < RS + 20) begin
      if (wr_ready || rd_vld != 0) bad = 1'b1;
      tick;
      n++;
    end
    wr_valid = 1'b0; rd_en = '0;
    check({tag, "_clear_cycles"}, n, RS);
    check({tag, "_clear_quiet"}, bad, 0);
    check({tag, "_clear_oob"}, oob_err, 0);
    check({tag, "_run_wr_ready"}, wr_ready, 1);
    for (int p = 0; p < NP; p++) last_d[p] = '0;
  endtask

  task automatic apply(input int i, input vec_t v);
    wr_valid = v.wv; wr_addr = v.wa; wr_data = v.wd; wr_strb = v.ws;
    rd_en = v.re; rd_addr = {v.ra1, v.ra0};
    tick;
    wr_valid = 1'b0; wr_strb = '0; rd_en = '0;
    check($sformatf("v%0d_vld_early", i), rd_vld, 0);
    tick;
    check($sformatf("v%0d_vld", i), rd_vld, v.re);
    for (int p = 0; p < NP; p++) begin
      if (v.re[p]) last_d[p] = (p == 0) ? v.e0 : v.e1;
      check($sformatf("v%0d_data%0d", i, p), port_data(p), last_d[p]);
    end
    check($sformatf("v%0d_oob", i), oob_err, v.eoob);
  endtask

  localparam int NV = 17;
  vec_t          vt [NV];
  logic [DW-1:0] coll;
  int            errs;
  int            idx;

  initial begin
`ifdef KAMACORE_MEM_FWD_EN
    coll = 32'h11111111;
`else
    coll = 32'hDEADBEEF;
`endif
    //          wv    wa     wd             ws     re     ra0    ra1    e0             e1             oob
    vt[0]  = '{1'b0, 8'd0,  32'h0,         4'h0, 2'b11, 8'd5,  8'd63, 32'h0,         32'h0,         1'b0};
    vt[1]  = '{1'b1, 8'd5,  32'hA1B2C3D4,  4'hF, 2'b00, 8'd0,  8'd0,  32'h0,         32'h0,         1'b0};
    vt[2]  = '{1'b1, 8'd5,  32'h000000EE,  4'h1, 2'b00, 8'd0,  8'd0,  32'h0,         32'h0,         1'b0};
    vt[3]  = '{1'b0, 8'd0,  32'h0,         4'h0, 2'b11, 8'd5,  8'd5,  32'hA1B2C3EE,  32'hA1B2C3EE,  1'b0};
    vt[4]  = '{1'b1, 8'd7,  32'hDEADBEEF,  4'hF, 2'b00, 8'd0,  8'd0,  32'h0,         32'h0,         1'b0};
    vt[5]  = '{1'b1, 8'd7,  32'h11111111,  4'hF, 2'b11, 8'd5,  8'd7,  32'hA1B2C3EE,  coll,          1'b0};
    vt[6]  = '{1'b0, 8'd0,  32'h0,         4'h0, 2'b11, 8'd7,  8'd7,  32'h11111111,  32'h11111111,  1'b0};
    vt[7]  = '{1'b1, 8'd7,  32'hFFFFFFFF,  4'h0, 2'b00, 8'd0,  8'd0,  32'h0,         32'h0,         1'b0};
    vt[8]  = '{1'b0, 8'd0,  32'h0,         4'h0, 2'b01, 8'd7,  8'd0,  32'h11111111,  32'h0,         1'b0};
    vt[9]  = '{1'b1, 8'd9,  32'h12345678,  4'hA, 2'b00, 8'd0,  8'd0,  32'h0,         32'h0,         1'b0};
    vt[10] = '{1'b0, 8'd0,  32'h0,         4'h0, 2'b11, 8'd9,  8'd0,  32'h12005600,  32'h0,         1'b0};
    vt[11] = '{1'b1, 8'd64, 32'hCAFEF00D,  4'hF, 2'b00, 8'd0,  8'd0,  32'h0,         32'h0,         1'b1};
    vt[12] = '{1'b0, 8'd0,  32'h0,         4'h0, 2'b11, 8'd0,  8'd67, 32'h0,         32'h0,         1'b1};
    vt[13] = '{1'b1, 8'd0,  32'h0BADC0DE,  4'hF, 2'b00, 8'd0,  8'd0,  32'h0,         32'h0,         1'b1};
    vt[14] = '{1'b0, 8'd0,  32'h0,         4'h0, 2'b01, 8'd0,  8'd0,  32'h0BADC0DE,  32'h0,         1'b1};
    vt[15] = '{1'b1, 8'd63, 32'h76543210,  4'hF, 2'b00, 8'd0,  8'd0,  32'h0,         32'h0,         1'b1};
    vt[16] = '{1'b0, 8'd0,  32'h0,         4'h0, 2'b11, 8'd63, 8'd255, 32'h76543210, 32'h0,         1'b1};

    reset_clear("init");

    // Every word reads back as zero after the clear sequence.
    errs = 0;
    for (int c = 0; c < RS + LAT; c++) begin
      if (c < RS) begin
        rd_en = 2'b11;
        rd_addr = {8'(RS - 1 - c), 8'(c)};
      end else begin
        rd_en = '0;
      end
      tick;
      idx = c + 1 - LAT;
      if (idx >= 0 && idx < RS) begin
        if (rd_vld !== 2'b11 || rd_data !== '0) errs++;
      end
    end
    rd_en = '0;
    check("clear_readback_errs", errs, 0);

    for (int i = 0; i < NV; i++) apply(i, vt[i]);

    // Back-to-back reads on both ports.
    for (int a = 0; a < 16; a++) begin
      wr_valid = 1'b1; wr_addr = 8'(a); wr_strb = 4'hF;
      wr_data = 32'h5A000000 + 32'(a) * 32'h00010203;
      tick;
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 16 + LAT; c++) begin
      if (c < 16) begin
        rd_en = 2'b11;
        rd_addr = {8'(15 - c), 8'(c)};
      end else begin
        rd_en = '0;
      end
      tick;
      idx = c + 1 - LAT;
      if (idx >= 0 && idx < 16) begin
        check($sformatf("tput%0d_vld", idx), rd_vld, 2'b11);
        check($sformatf("tput%0d_d0", idx), port_data(0), 32'h5A000000 + 32'(idx) * 32'h00010203);
        check($sformatf("tput%0d_d1", idx), port_data(1), 32'h5A000000 + 32'(15 - idx) * 32'h00010203);
      end else begin
        check($sformatf("tput_c%0d_idle", c), rd_vld, 0);
      end
    end

    // Reset while a read is in flight.
    rd_en = 2'b11; rd_addr = {8'd2, 8'd1};
    tick;
    rd_en = '0; rst_n = 1'b0;
    tick;
    check("midrst_vld", rd_vld, 0);
    check("midrst_data", rd_data, 0);
    check("midrst_oob", oob_err, 0);
    check("midrst_init_done", init_done, 0);
    reset_clear("midrst");
    check("midrst_no_stale", rd_vld, 0);
    rd_en = 2'b01; rd_addr = {8'd0, 8'd1};
    tick;
    rd_en = '0;
    tick;
    check("midrst_read_vld", rd_vld, 2'b01);
    check("midrst_read_data", port_data(0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
